mult_seq_ctrl: RTL

//  - Sequencer for the shift-add micro multiplier datapath. On a start strobe it steps
//    the datapath through load, per-bit evaluate/add/shift and result capture.
//  - It then signals completion with a one-cycle done pulse.
//  - Sits between the top-level pins and the datapath. Drives the datapath strobes by

---
 rtl/mult_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the shift-add micro multiplier datapath.
//   A start strobe in IDLE launches LOAD, then N rounds of EVAL -> (ADD) -> SHIFT,
//   then a single-cycle DONE that loads the product register and pulses done.
// Ports:
//   sys_clk, sys_rst       clock (rising) / asynchronous active-high reset
//   start                  launch request, only looked at in IDLE
//   flag, sr_zero          datapath status: multiplier LSB, shift register empty
//   busy, done             status to the pins
//   enA enB ABsel enDPO    operand / product register controls
//   sr_c1 sr_c0 enSR SRsel shift-register mode, enable, load source
//   alu_c2..alu_c0 enACC clrACC  ALU op and accumulator controls
//   bit_cnt                multiplier bits already processed
// Build option: define EARLY_EXIT_EN to finish as soon as the shift register
//   empties (checked in EVAL); otherwise sr_zero is ignored.
module mult_seq_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             flag,
  input  logic             sr_zero,
  output logic             busy,
  output logic             done,
  output logic             enA,
  output logic             enB,
  output logic             ABsel,
  output logic             enDPO,
  output logic             sr_c1,
  output logic             sr_c0,
  output logic             enSR,
  output logic             SRsel,
  output logic             alu_c2,
  output logic             alu_c1,
  output logic             alu_c0,
  output logic             enACC,
  output logic             clrACC,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EVAL, S_ADD, S_SHIFT, S_DONE
  } state_t;

  state_t      state, nxt;
  logic [14:0] strb_q;

`ifndef EARLY_EXIT_EN
  logic unused_sr_zero;
  assign unused_sr_zero = sr_zero;
`endif

  // Strobe image of a state; registered together with the state so every output
  // is a flop that always matches the state register.
  function automatic logic [14:0] decode(input state_t s);
    logic b_busy, b_done, b_ena, b_enb, b_absel, b_endpo, b_c1, b_c0, b_ensr, b_srsel;
    logic b_a2, b_a1, b_a0, b_enacc, b_clracc;
    {b_busy, b_done, b_ena, b_enb, b_absel, b_endpo, b_c1, b_c0, b_ensr, b_srsel,
     b_a2, b_a1, b_a0, b_enacc, b_clracc} = '0;
    b_busy = (s != S_IDLE);
    case (s)
      S_LOAD:  begin
        b_ena = 1'b1; b_enb = 1'b1; b_ensr = 1'b1; b_c1 = 1'b1;
        b_srsel = 1'b1; b_clracc = 1'b1;
      end
      S_ADD:   begin b_a0 = 1'b1; b_enacc = 1'b1; end
      S_SHIFT: begin b_ensr = 1'b1; b_c0 = 1'b1; b_ena = 1'b1; b_absel = 1'b1; end
      S_DONE:  begin b_endpo = 1'b1; b_done = 1'b1; end
      default: ;
    endcase
    return {b_busy, b_done, b_ena, b_enb, b_absel, b_endpo, b_c1, b_c0, b_ensr, b_srsel,
            b_a2, b_a1, b_a0, b_enacc, b_clracc};
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  nxt = S_EVAL;
`ifdef EARLY_EXIT_EN
      // Nothing left to add once the multiplier has shifted out to zero.
      S_EVAL:  nxt = sr_zero ? S_DONE : (flag ? S_ADD : S_SHIFT);
`else
      S_EVAL:  nxt = flag ? S_ADD : S_SHIFT;
`endif
      S_ADD:   nxt = S_SHIFT;
      // Compare the pre-increment count: this SHIFT retires the last bit.
      S_SHIFT: nxt = (bit_cnt == CNT_W'(N - 1)) ? S_DONE : S_EVAL;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      strb_q  <= '0;
      bit_cnt <= '0;
    end else begin
      state  <= nxt;
      strb_q <= decode(nxt);
      if (state == S_LOAD)       bit_cnt <= '0;
      else if (state == S_SHIFT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign {busy, done, enA, enB, ABsel, enDPO, sr_c1, sr_c0, enSR, SRsel,
          alu_c2, alu_c1, alu_c0, enACC, clrACC} = strb_q;

endmodule
